// File: rtl/pac_move_ctrl.sv
// pac_move_ctrl: steps Pac-Man through the maze once per game tick.
//
// At a tile-aligned position the requested direction and the current direction
// are checked against the wall map over a valid/ready handshake. Between tiles
// Pac-Man keeps moving, and may reverse without asking the wall map. Each step
// moves STEP pixels. The x axis wraps through the side tunnel. A mouth toggle
// every MOUTH_DIV steps switches the sprite code between the directional
// sprite and the round (closed) sprite.
//
// Ports:
//   clk, rst      rising-edge clock, synchronous active-high reset
//   tick          one-cycle game-step pulse (dropped while busy)
//   req_dir       requested direction, one-hot {L,U,R,D}; other values = none
//   query_valid   wall query pending; query_col/query_row name the tile
//   wall_ready    wall map answers this cycle; wall_blocked = 1 means wall
//   pac_x, pac_y  top-left pixel position
//   cur_dir       committed direction (0 = none)
//   sprite_dir    direction code for the sprite ROM (0 = closed mouth)
//   moving        last tick produced a step
//   busy          movement sequencer not idle
module pac_move_ctrl #(
    parameter int unsigned TILE      = 24,
    parameter int unsigned STEP      = 2,
    parameter int unsigned COLS      = 28,
    parameter int unsigned ROWS      = 31,
    parameter int unsigned START_COL = 13,
    parameter int unsigned START_ROW = 23,
    parameter int unsigned MOUTH_DIV = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic [3:0] req_dir,
    output logic       query_valid,
    output logic [4:0] query_col,
    output logic [4:0] query_row,
    input  logic       wall_ready,
    input  logic       wall_blocked,
    output logic [9:0] pac_x,
    output logic [9:0] pac_y,
    output logic [3:0] cur_dir,
    output logic [3:0] sprite_dir,
    output logic       moving,
    output logic       busy
);

    localparam int unsigned X_SPAN  = COLS * TILE;
    localparam logic [9:0]  STEP_PX = 10'(STEP);
    localparam logic [9:0]  X_WRAP  = 10'(X_SPAN - STEP);
    localparam logic [9:0]  X_START = 10'(START_COL * TILE);
    localparam logic [9:0]  Y_START = 10'(START_ROW * TILE);
    localparam int unsigned MCW     = $clog2(MOUTH_DIV + 1);
    localparam logic [MCW-1:0] MDIV = MCW'(MOUTH_DIV);

    localparam logic [3:0] DIR_L = 4'b1000;
    localparam logic [3:0] DIR_U = 4'b0100;
    localparam logic [3:0] DIR_R = 4'b0010;
    localparam logic [3:0] DIR_D = 4'b0001;

    typedef enum logic [1:0] {StIdle, StQReq, StQCur, StStep} state_e;

    state_e         state_q, state_d;
    logic [9:0]     x_q, x_d;
    logic [9:0]     y_q, y_d;
    logic [3:0]     dir_q, dir_d;
    logic [3:0]     lat_q, lat_d;     // request latched on entry to StQReq
    logic [3:0]     spr_q, spr_d;
    logic           moving_q, moving_d;
    logic           mouth_q, mouth_d;
    logic [MCW-1:0] mcnt_q, mcnt_d;
    logic [MCW-1:0] mcnt_inc;

    int unsigned    x_u, y_u;
    logic           aligned;
    logic [3:0]     q_dir;
    int             nbr_col, nbr_row;
    logic           col_oob, row_oob;
    logic           in_query, issue;
    logic           resolved, blocked;

    function automatic logic [3:0] opposite(input logic [3:0] d);
        return {d[1], d[0], d[3], d[2]};
    endfunction

    assign x_u      = {22'd0, x_q};
    assign y_u      = {22'd0, y_q};
    assign aligned  = ((x_u % TILE) == 0) && ((y_u % TILE) == 0);
    assign mcnt_inc = mcnt_q + MCW'(1);

    // Neighbour tile in the direction being queried.
    assign q_dir = (state_q == StQReq) ? lat_q : dir_q;

    always_comb begin
        nbr_col = int'(x_u / TILE);
        nbr_row = int'(y_u / TILE);
        case (q_dir)
            DIR_L:   nbr_col = nbr_col - 1;
            DIR_R:   nbr_col = nbr_col + 1;
            DIR_U:   nbr_row = nbr_row - 1;
            DIR_D:   nbr_row = nbr_row + 1;
            default: ;
        endcase
    end

    // Off the side edge is the tunnel (open); off top/bottom is solid.
    assign col_oob  = (nbr_col < 0) || (nbr_col >= int'(COLS));
    assign row_oob  = (nbr_row < 0) || (nbr_row >= int'(ROWS));
    assign in_query = (state_q == StQReq) || (state_q == StQCur);
    assign issue    = in_query && !col_oob && !row_oob;
    assign resolved = col_oob || row_oob || wall_ready;
    assign blocked  = row_oob || (!col_oob && wall_blocked);

    assign query_valid = issue;
    assign query_col   = issue ? 5'(nbr_col) : 5'd0;
    assign query_row   = issue ? 5'(nbr_row) : 5'd0;

    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        y_d      = y_q;
        dir_d    = dir_q;
        lat_d    = lat_q;
        moving_d = moving_q;
        mouth_d  = mouth_q;
        mcnt_d   = mcnt_q;
        spr_d    = spr_q;

        unique case (state_q)
            StIdle: begin
                if (tick) begin
                    if (!aligned) begin
                        // Mid-tile reversal: the tile just left is known open.
                        if ((dir_q != 4'b0000) && (req_dir == opposite(dir_q))) begin
                            dir_d = req_dir;
                        end
                        state_d = StStep;
                    end else if ($onehot(req_dir) && (req_dir != dir_q)) begin
                        lat_d   = req_dir;
                        state_d = StQReq;
                    end else if (dir_q != 4'b0000) begin
                        state_d = StQCur;
                    end else begin
                        moving_d = 1'b0;
                    end
                end
            end

            StQReq: begin
                if (resolved) begin
                    if (!blocked) begin
                        dir_d   = lat_q;
                        state_d = StStep;
                    end else if (dir_q != 4'b0000) begin
                        state_d = StQCur;
                    end else begin
                        moving_d = 1'b0;
                        state_d  = StIdle;
                    end
                end
            end

            StQCur: begin
                if (resolved) begin
                    if (!blocked) begin
                        state_d = StStep;
                    end else begin
                        moving_d = 1'b0;
                        state_d  = StIdle;
                    end
                end
            end

            StStep: begin
                case (dir_q)
                    DIR_L:   x_d = (x_q == 10'd0) ? X_WRAP : x_q - STEP_PX;
                    DIR_R:   x_d = ((x_u + STEP) >= X_SPAN) ? 10'd0 : x_q + STEP_PX;
                    DIR_U:   y_d = y_q - STEP_PX;
                    DIR_D:   y_d = y_q + STEP_PX;
                    default: ;
                endcase
                moving_d = 1'b1;
                if (mcnt_inc == MDIV) begin
                    mcnt_d  = '0;
                    mouth_d = !mouth_q;
                end else begin
                    mcnt_d = mcnt_inc;
                end
                state_d = StIdle;
            end

            default: state_d = StIdle;
        endcase

        // Sprite code follows every step and every direction change.
        if ((state_q == StStep) || (dir_d != dir_q)) begin
            spr_d = mouth_d ? dir_d : 4'b0000;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            x_q      <= X_START;
            y_q      <= Y_START;
            dir_q    <= 4'b0000;
            lat_q    <= 4'b0000;
            spr_q    <= 4'b0000;
            moving_q <= 1'b0;
            mouth_q  <= 1'b0;
            mcnt_q   <= '0;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            y_q      <= y_d;
            dir_q    <= dir_d;
            lat_q    <= lat_d;
            spr_q    <= spr_d;
            moving_q <= moving_d;
            mouth_q  <= mouth_d;
            mcnt_q   <= mcnt_d;
        end
    end

    assign pac_x      = x_q;
    assign pac_y      = y_q;
    assign cur_dir    = dir_q;
    assign sprite_dir = spr_q;
    assign moving     = moving_q;
    assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_pac_move_ctrl.sv
// Bench for pac_move_ctrl. Stimulus pushes the expected tick outcome and the
// expected wall queries into queues; two monitors pop and compare whenever the
// DUT finishes a tick or presents a query.
module tb_pac_move_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick = 1'b0;
    logic [3:0] req_dir = 4'b0000;
    logic       query_valid;
    logic [4:0] query_col;
    logic [4:0] query_row;
    logic       wall_ready = 1'b0;
    logic       wall_blocked;
    logic [9:0] pac_x;
    logic [9:0] pac_y;
    logic [3:0] cur_dir;
    logic [3:0] sprite_dir;
    logic       moving;
    logic       busy;

    // Wall map model: at most one blocked tile, plus a ready stall.
    logic       blk_en = 1'b0;
    logic [4:0] blk_col = 5'd0;
    logic [4:0] blk_row = 5'd0;
    int         stall = 0;
    int         wait_cnt = 0;

    int n_cmp = 0;
    int n_bad = 0;

    logic [28:0] tick_q[$];
    logic [9:0]  qry_q[$];

    localparam logic [3:0] L = 4'b1000;
    localparam logic [3:0] U = 4'b0100;
    localparam logic [3:0] R = 4'b0010;

    pac_move_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .tick        (tick),
        .req_dir     (req_dir),
        .query_valid (query_valid),
        .query_col   (query_col),
        .query_row   (query_row),
        .wall_ready  (wall_ready),
        .wall_blocked(wall_blocked),
        .pac_x       (pac_x),
        .pac_y       (pac_y),
        .cur_dir     (cur_dir),
        .sprite_dir  (sprite_dir),
        .moving      (moving),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    assign wall_blocked = blk_en && (query_col == blk_col) && (query_row == blk_row);

    function automatic logic [28:0] pack(int px, int py, logic [3:0] d, logic [3:0] sp,
                                         logic m);
        return {10'(px), 10'(py), d, sp, m};
    endfunction

    function automatic logic [3:0] spr(int s, logic [3:0] d);
        return (((s / 4) % 2) == 1) ? d : 4'b0000;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    // Wall responder: ready after `stall` cycles of query_valid.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (wall_ready) begin
                wall_ready = 1'b0;
                wait_cnt   = 0;
            end
            if (query_valid) begin
                if (wait_cnt >= stall) wall_ready = 1'b1;
                else wait_cnt++;
            end
        end
    end

    // Query monitor: col/row must match the expected query on every valid cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (query_valid) begin
                if (qry_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL query_unexpected: got col %0d row %0d, required no query",
                             query_col, query_row);
                end else begin
                    check("query_tile", {22'd0, query_col, query_row}, {22'd0, qry_q[0]});
                    if (wall_ready) void'(qry_q.pop_front());
                end
            end
        end
    end

    // Tick monitor: an accepted tick completes when the sequencer is idle again.
    initial begin
        forever begin
            @(negedge clk);
            if (tick && !busy) begin
                int n;
                n = 0;
                do begin
                    @(negedge clk);
                    n++;
                end while (busy && n < 50);
                if (busy) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL tick_timeout: got busy after %0d cycles, required idle", n);
                end else if (tick_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL tick_unexpected: got x=%0d y=%0d, required no tick",
                             pac_x, pac_y);
                end else begin
                    check("tick_result", {3'd0, pac_x, pac_y, cur_dir, sprite_dir, moving},
                          {3'd0, tick_q.pop_front()});
                end
            end
        end
    end

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (busy) begin
            n_cmp++;
            n_bad++;
            $display("FAIL idle_timeout: got busy=1, required 0");
        end
    endtask

    task automatic pulse_tick();
        @(posedge clk);
        #1 tick = 1'b1;
        @(posedge clk);
        #1 tick = 1'b0;
    endtask

    task automatic do_tick();
        pulse_tick();
        wait_idle();
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int x;
        int s;
        bit passed;

        // Reset state.
        do_reset();
        check("reset_state", {3'd0, pac_x, pac_y, cur_dir, sprite_dir, moving},
              {3'd0, pack(312, 552, 4'b0000, 4'b0000, 1'b0)});
        check("reset_qv_busy", {30'd0, query_valid, busy}, 32'd0);

        // Open corridor to the right: one query at the first tick only.
        x = 312;
        s = 0;
        req_dir = R;
        for (int i = 1; i <= 12; i++) begin
            if (i == 1) qry_q.push_back({5'd14, 5'd23});
            x += 2;
            s++;
            tick_q.push_back(pack(x, 552, R, spr(s, R), 1'b1));
            do_tick();
        end

        // Wall straight ahead: no step, direction kept.
        blk_en  = 1'b1;
        blk_col = 5'd15;
        blk_row = 5'd23;
        qry_q.push_back({5'd15, 5'd23});
        tick_q.push_back(pack(336, 552, R, spr(s, R), 1'b0));
        do_tick();

        // Blocked turn up: falls back to the open current direction.
        blk_col = 5'd14;
        blk_row = 5'd22;
        req_dir = U;
        qry_q.push_back({5'd14, 5'd22});
        qry_q.push_back({5'd15, 5'd23});
        s++;
        tick_q.push_back(pack(338, 552, R, spr(s, R), 1'b1));
        do_tick();
        blk_en = 1'b0;

        // Mid-tile reversal after a fresh reset.
        do_reset();
        check("reset_again", {3'd0, pac_x, pac_y, cur_dir, sprite_dir, moving},
              {3'd0, pack(312, 552, 4'b0000, 4'b0000, 1'b0)});
        req_dir = R;
        qry_q.push_back({5'd14, 5'd23});
        tick_q.push_back(pack(314, 552, R, 4'b0000, 1'b1));
        do_tick();
        tick_q.push_back(pack(316, 552, R, 4'b0000, 1'b1));
        do_tick();
        req_dir = L;
        tick_q.push_back(pack(314, 552, L, 4'b0000, 1'b1));
        do_tick();
        s = 3;
        x = 314;

        // Run left through the tunnel with a stalling wall map.
        stall  = 3;
        passed = 1'b0;
        while (!(passed && x == 648)) begin
            if ((x % 24) == 0 && x != 0) qry_q.push_back({5'(x / 24 - 1), 5'd23});
            if (x == 0) begin
                passed = 1'b1;
                x = 670;
            end else begin
                x -= 2;
            end
            s++;
            tick_q.push_back(pack(x, 552, L, spr(s, L), 1'b1));
            do_tick();
        end

        // Tick during a stalled handshake is dropped.
        qry_q.push_back({5'd26, 5'd23});
        s++;
        tick_q.push_back(pack(646, 552, L, spr(s, L), 1'b1));
        pulse_tick();
        pulse_tick();
        wait_idle();

        repeat (5) @(posedge clk);
        check("ticks_left", 32'(tick_q.size()), 32'd0);
        check("queries_left", 32'(qry_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pac_move_ctrl.md
# pac_move_ctrl

Sequences Pac-Man's movement through the maze, one game tick at a time. It latches the player's requested direction and asks the maze wall map whether the neighbouring tile is open over a valid/ready handshake. It then advances Pac-Man's pixel position and drives the 4-bit one-hot direction code consumed by the Pac-Man sprite ROM, including the mouth-animation toggle. It sits between the joystick/debounce logic and the wall-map and sprite renderers.

## Interface
- `TILE`, 24: tile edge in screen pixels (12×12 sprite doubled); must be a multiple of `STEP`.
- `STEP`, 2: pixels moved per executed step.
- `COLS`, 28: maze columns.
- `ROWS`, 31: maze rows.
- `START_COL`, 13: reset tile column.
- `START_ROW`, 23: reset tile row.
- `MOUTH_DIV`, 4: executed steps per mouth toggle.

- `clk`  in  1  single clock; everything is on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `tick`  in  1  one-cycle game-step pulse.
- `req_dir`  in  4  requested direction, one-hot {L,U,R,D} = 1000/0100/0010/0001; any other value means "no request".
- `query_valid`  out  1  wall query pending.
- `query_col`  out  5  tile column queried.
- `query_row`  out  5  tile row queried.
- `wall_ready`  in  1  wall map answers this cycle.
- `wall_blocked`  in  1  answer: 1 = wall; sampled only when `query_valid && wall_ready`.
- `pac_x`  out  10  top-left pixel x, range 0..COLS·TILE−1.
- `pac_y`  out  10  top-left pixel y.
- `cur_dir`  out  4  committed direction (0000 = none).
- `sprite_dir`  out  4  direction code to the sprite ROM.
- `moving`  out  1  last tick produced a step.
- `busy`  out  1  FSM not in IDLE.

## Operation
- Reset values:
  - `pac_x` = START_COL·TILE, `pac_y` = START_ROW·TILE.
  - `cur_dir`, `sprite_dir`, `query_col`, `query_row` = 0.
  - `moving`, `query_valid`, `busy`, mouth state, mouth counter = 0.
  - FSM = IDLE.
- Aligned: `pac_x % TILE == 0 && pac_y % TILE == 0`. Current tile = (pac_x/TILE, pac_y/TILE).
- FSM states: IDLE, Q_REQ, Q_CUR, STEP.
- IDLE, on `tick`:
  - Not aligned, `req_dir` exactly opposite `cur_dir`: `cur_dir` ← `req_dir`, go to STEP (reversal needs no query).
  - Not aligned otherwise: go to STEP.
  - Aligned, valid `req_dir` ≠ `cur_dir`: go to Q_REQ.
  - Aligned otherwise, `cur_dir` ≠ 0: go to Q_CUR.
  - Aligned otherwise, `cur_dir` = 0: stay in IDLE, `moving` ← 0.
- Q_REQ / Q_CUR query the neighbour tile in `req_dir` (latched on entry) or in `cur_dir`.
  - `query_valid` = 1, with col/row held stable until `wall_ready`.
  - Out-of-range neighbour (col −1 or COLS): issue no query; treat as open. Row −1 or ROWS: treat as blocked.
  - Q_REQ open: `cur_dir` ← latched request, go to STEP.
  - Q_REQ blocked: go to Q_CUR if `cur_dir` ≠ 0, else IDLE with `moving` ← 0.
  - Q_CUR open: go to STEP.
  - Q_CUR blocked: go to IDLE, `moving` ← 0; `cur_dir` is retained.
- STEP (one cycle):
  - Move `STEP` px along `cur_dir`.
  - x wraps modulo COLS·TILE (tunnel): 0 moving L gives COLS·TILE−STEP; COLS·TILE−STEP moving R gives 0.
  - y never wraps.
  - `moving` ← 1; mouth counter increments; when it reaches MOUTH_DIV it clears and the mouth toggles.
  - Return to IDLE.
- `sprite_dir` = mouth open ? `cur_dir` : 0000 (closed mouth selects the default round sprite). It is registered and updated in STEP and whenever `cur_dir` changes.
- `tick` arriving while `busy` is dropped, not queued.

## Timing
- No-query step: `tick` at cycle n → STEP at n+1 → new `pac_x/pac_y` visible at n+2.
- Query step: `query_valid` rises at n+1; with `wall_ready` at cycle k, STEP runs at k+1 and the position updates at k+2.
- Two queries (request blocked): total latency is the sum of both handshakes plus 2 cycles.
- `query_valid` deasserts the cycle after `wall_ready`.
- `rst` mid-handshake: every output returns to its reset value on the next edge; `query_valid` drops without waiting for ready.

## Test plan
- Reset: assert `rst` → `pac_x`=312, `pac_y`=552, `cur_dir`=0, `sprite_dir`=0, `query_valid`=0, `busy`=0.
- Open corridor: `req_dir`=0010, wall always open, 12 ticks → `pac_x`=336, exactly one query issued (at tick 1), `moving`=1, `sprite_dir` toggles 0010/0000 every 4 steps.
- Wall stop: `cur_dir`=R at aligned tile, `wall_blocked`=1 → `pac_x` unchanged, `moving`=0, `cur_dir`=0010.
- Blocked turn: request U blocked while R is open → Q_REQ then Q_CUR queries seen, `pac_x` += 2, `cur_dir` stays 0010.
- Mid-tile reversal: `pac_x`=316 moving R, `req_dir`=1000 → no query, `pac_x`=314, `cur_dir`=1000.
- Tunnel plus stall: `pac_x`=0 moving L with `wall_ready` held low 3 cycles → query absent (col −1), `pac_x`=670. Then a `tick` during a stalled handshake → dropped, and col/row stay stable until ready.
